// File: rtl/dual_issue_fetch_queue.sv
// Purpose: fetch-to-decode instruction queue. Accepts one {instr, pc} per cycle
//          and presents the two oldest entries as an issue pair to dual decode.
// Latency: an enqueued entry is visible at the slot outputs the next cycle (no bypass).
// Backpressure: enq_ready_o drops when full, and only registered occupancy drives it.
//          A same-cycle pop does not make room.
// Ports:
//   clk_i, reset_n_i                        clock, async active-low reset
//   enq_v_i/enq_instr_i/enq_pc_i/enq_ready_o  fetch-side valid/ready enqueue
//   deq_v0_o/deq_instr0_o/deq_pc0_o         slot 0 (oldest entry)
//   deq_v1_o/deq_instr1_o/deq_pc1_o         slot 1 (second-oldest entry)
//   yumi_i, do_single_issue_i               decode consumes one or two entries
//   flush_i                                 redirect, empties the queue
//   count_o                                 current occupancy
module dual_issue_fetch_queue #(
  parameter int els_p      = 4,
  parameter int pc_width_p = 22
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_v_i,
  input  logic [31:0]                enq_instr_i,
  input  logic [pc_width_p-1:0]      enq_pc_i,
  output logic                       enq_ready_o,
  output logic                       deq_v0_o,
  output logic [31:0]                deq_instr0_o,
  output logic [pc_width_p-1:0]      deq_pc0_o,
  output logic                       deq_v1_o,
  output logic [31:0]                deq_instr1_o,
  output logic [pc_width_p-1:0]      deq_pc1_o,
  input  logic                       yumi_i,
  input  logic                       do_single_issue_i,
  input  logic                       flush_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int          ptr_w_lp = $clog2(els_p);
  localparam int          cnt_w_lp = $clog2(els_p+1);
  localparam logic [31:0] nop_lp   = 32'h00000013;

  // Storage is deliberately not reset; validity comes from r_count alone.
  logic [31:0]           r_instr [els_p];
  logic [pc_width_p-1:0] r_pc    [els_p];

  logic [ptr_w_lp-1:0]   r_rd_ptr;
  logic [ptr_w_lp-1:0]   r_wr_ptr;
  logic [cnt_w_lp-1:0]   r_count;

  logic                  w_v0;
  logic                  w_v1;
  logic                  w_enq_fire;
  logic [1:0]            w_pop_cnt;
  logic [ptr_w_lp-1:0]   w_rd1_ptr;

  assign w_v0        = (r_count != '0);
  assign w_v1        = (r_count >= cnt_w_lp'(2));
  assign enq_ready_o = (r_count < cnt_w_lp'(els_p));
  assign w_enq_fire  = enq_v_i & enq_ready_o & ~flush_i;

  // Power-of-two depth: the pointer width wraps modulo els_p for free.
  assign w_rd1_ptr   = r_rd_ptr + ptr_w_lp'(1);

  // A yumi with nothing in slot 0 is ignored rather than corrupting the count.
  always_comb begin
    w_pop_cnt = 2'd0;
    if (yumi_i && !flush_i && w_v0) begin
      w_pop_cnt = (w_v1 && !do_single_issue_i) ? 2'd2 : 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + ptr_w_lp'(w_pop_cnt);
      if (w_enq_fire) begin
        r_wr_ptr <= r_wr_ptr + ptr_w_lp'(1);
      end
      r_count  <= r_count + cnt_w_lp'(w_enq_fire) - cnt_w_lp'(w_pop_cnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq_fire) begin
      r_instr[r_wr_ptr] <= enq_instr_i;
      r_pc[r_wr_ptr]    <= enq_pc_i;
    end
  end

  // Empty slots show a NOP at PC 0 so decode never sees stale storage.
  assign deq_v0_o     = w_v0;
  assign deq_instr0_o = w_v0 ? r_instr[r_rd_ptr]  : nop_lp;
  assign deq_pc0_o    = w_v0 ? r_pc[r_rd_ptr]     : '0;
  assign deq_v1_o     = w_v1;
  assign deq_instr1_o = w_v1 ? r_instr[w_rd1_ptr] : nop_lp;
  assign deq_pc1_o    = w_v1 ? r_pc[w_rd1_ptr]    : '0;
  assign count_o      = r_count;

  a_yumi_needs_v0: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !w_v0)
  );

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
module tb_dual_issue_fetch_queue;

  localparam int          ELS = 4;
  localparam int          PCW = 22;
  localparam logic [31:0] NOP = 32'h00000013;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enq_v = 1'b0;
  logic [31:0]    enq_instr = '0;
  logic [PCW-1:0] enq_pc = '0;
  logic           enq_ready;
  logic           v0, v1;
  logic [31:0]    instr0, instr1;
  logic [PCW-1:0] pc0, pc1;
  logic           yumi = 1'b0;
  logic           single = 1'b0;
  logic           flush = 1'b0;
  logic [2:0]     count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
  } ent_t;

  // Reference model: an ordered list of queued entries, oldest first.
  ent_t q[$];

  dual_issue_fetch_queue #(.els_p(ELS), .pc_width_p(PCW)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .enq_v_i          (enq_v),
    .enq_instr_i      (enq_instr),
    .enq_pc_i         (enq_pc),
    .enq_ready_o      (enq_ready),
    .deq_v0_o         (v0),
    .deq_instr0_o     (instr0),
    .deq_pc0_o        (pc0),
    .deq_v1_o         (v1),
    .deq_instr1_o     (instr1),
    .deq_pc1_o        (pc1),
    .yumi_i           (yumi),
    .do_single_issue_i(single),
    .flush_i          (flush),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Update the model from the current inputs, then advance one clock.
  task automatic tick();
    int  sz;
    int  pop;
    bit  enq;
    sz  = q.size();
    pop = 0;
    enq = enq_v && (sz < ELS);
    if (flush) begin
      q.delete();
    end else begin
      if (yumi && sz >= 1) pop = (sz >= 2 && !single) ? 2 : 1;
      for (int k = 0; k < pop; k++) q.delete(0);
      if (enq) q.push_back('{enq_instr, enq_pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int pc, input bit y, input bit s, input bit f);
    enq_v     = v;
    enq_pc    = PCW'(pc);
    enq_instr = 32'hCAFE0000 | 32'(pc);
    yumi      = y;
    single    = s;
    flush     = f;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({v0, v1} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", {v0, v1}); end
    checks++; if (instr0 !== NOP || instr1 !== NOP) begin errors++; $display("FAIL reset_nop got %h/%h want %h", instr0, instr1, NOP); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", enq_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 4; i++) drive(1, 'h10 + i, 0, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", enq_ready); end
    drive(1, 'h14, 0, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d want 4", count); end
    checks++; if (pc0 !== PCW'('h10) || pc1 !== PCW'('h11)) begin errors++; $display("FAIL full_slots got %h/%h want 10/11", pc0, pc1); end
    checks++; if (instr0 !== 32'hCAFE0010) begin errors++; $display("FAIL full_instr0 got %h want cafe0010", instr0); end
  endtask

  task automatic test_dual_pop();
    drive(0, 0, 1, 0, 0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL dual_count got %0d want 2", count); end
    checks++; if (pc0 !== PCW'('h12) || pc1 !== PCW'('h13)) begin errors++; $display("FAIL dual_slots got %h/%h want 12/13", pc0, pc1); end
  endtask

  task automatic test_single_pop_enq();
    drive(1, 'h14, 1, 1, 0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL single_enq_count got %0d want 2", count); end
    checks++; if (pc0 !== PCW'('h13) || pc1 !== PCW'('h14)) begin errors++; $display("FAIL wrap_slots got %h/%h want 13/14", pc0, pc1); end
    checks++; if (instr1 !== 32'hCAFE0014) begin errors++; $display("FAIL wrap_instr1 got %h want cafe0014", instr1); end
  endtask

  task automatic test_pop_one();
    drive(0, 0, 1, 1, 0);
    checks++; if (count !== 3'd1 || v1 !== 1'b0 || pc1 !== '0 || instr1 !== NOP) begin
      errors++; $display("FAIL one_left got cnt=%0d v1=%b pc1=%h i1=%h want 1/0/0/%h", count, v1, pc1, instr1, NOP); end
    drive(0, 0, 1, 0, 0);
    checks++; if (count !== 3'd0 || v0 !== 1'b0 || instr0 !== NOP) begin
      errors++; $display("FAIL pop_one got cnt=%0d v0=%b i0=%h want 0/0/%h", count, v0, instr0, NOP); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive(1, 'h30 + i, 0, 0, 0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_flush_count got %0d want 3", count); end
    drive(1, 'h33, 1, 0, 1);
    checks++; if (count !== 3'd0 || {v0, v1} !== 2'b00) begin
      errors++; $display("FAIL flush got cnt=%0d v=%b want 0/00", count, {v0, v1}); end
    drive(1, 'h40, 0, 0, 0);
    checks++; if (v0 !== 1'b1 || pc0 !== PCW'('h40) || v1 !== 1'b0) begin
      errors++; $display("FAIL post_flush got v0=%b pc0=%h v1=%b want 1/40/0", v0, pc0, v1); end
  endtask

  task automatic test_reset_mid();
    drive(1, 'h41, 0, 0, 0);
    drive(1, 'h42, 0, 0, 0);
    enq_v = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset_count got %0d want 3", count); end
    reset_n = 1'b0;
    #2;
    checks++; if (count !== 3'd0 || {v0, v1} !== 2'b00 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got cnt=%0d v=%b rdy=%b want 0/00/1", count, {v0, v1}, enq_ready); end
    checks++; if (instr0 !== NOP || instr1 !== NOP) begin errors++; $display("FAIL async_reset_nop got %h/%h", instr0, instr1); end
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", count); end
  endtask

  task automatic test_random();
    logic           e_v0, e_v1;
    logic [31:0]    e_i0, e_i1;
    logic [PCW-1:0] e_p0, e_p1;
    for (int c = 0; c < 3000; c++) begin
      enq_v     = ($urandom_range(0, 3) != 0);
      enq_instr = $urandom;
      enq_pc    = PCW'($urandom);
      yumi      = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      single    = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 40) == 0);
      tick();
      e_v0 = (q.size() >= 1);
      e_v1 = (q.size() >= 2);
      e_i0 = e_v0 ? q[0].instr : NOP;
      e_p0 = e_v0 ? q[0].pc    : '0;
      e_i1 = e_v1 ? q[1].instr : NOP;
      e_p1 = e_v1 ? q[1].pc    : '0;
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, q.size()); end
      checks++; if (enq_ready !== (q.size() < ELS)) begin errors++; $display("FAIL rnd_ready c=%0d got %b", c, enq_ready); end
      checks++; if ({v0, v1} !== {e_v0, e_v1}) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, {v0, v1}, {e_v0, e_v1}); end
      checks++; if (instr0 !== e_i0 || pc0 !== e_p0) begin errors++; $display("FAIL rnd_slot0 c=%0d got %h/%h want %h/%h", c, instr0, pc0, e_i0, e_p0); end
      checks++; if (instr1 !== e_i1 || pc1 !== e_p1) begin errors++; $display("FAIL rnd_slot1 c=%0d got %h/%h want %h/%h", c, instr1, pc1, e_i1, e_p1); end
    end
    enq_v = 1'b0; yumi = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_dual_pop();
    test_single_pop_enq();
    test_pop_one();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_fetch_queue.md
Name: dual_issue_fetch_queue

Overview:
- Instruction queue between the vanilla core's icache/fetch stage and the dual-issue decode stage.
- Accepts at most one fetched instruction and its PC per cycle.
- Presents the two oldest entries, slot 0 (older) and slot 1, as an instruction pair to the dual decoder.
- The decoder answers with a single-issue indication; the queue retires one or two entries per accepted cycle, and a redirect flush empties it.

Parameters:
- els_p, 4, queue depth in instructions; power of two, >= 2.
- pc_width_p, 22, width of the stored word PC.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- enq_v_i  in  1  fetch presents a valid instruction.
- enq_instr_i  in  32  fetched instruction word.
- enq_pc_i  in  pc_width_p  word PC of the fetched instruction.
- enq_ready_o  out  1  queue can accept an instruction this cycle.
- deq_v0_o  out  1  slot 0 (oldest entry) valid.
- deq_instr0_o  out  32  slot 0 instruction.
- deq_pc0_o  out  pc_width_p  slot 0 PC.
- deq_v1_o  out  1  slot 1 (second-oldest entry) valid.
- deq_instr1_o  out  32  slot 1 instruction.
- deq_pc1_o  out  pc_width_p  slot 1 PC.
- yumi_i  in  1  decode consumes instructions this cycle.
- do_single_issue_i  in  1  decode consumes slot 0 only.
- flush_i  in  1  redirect; discard all entries.
- count_o  out  $clog2(els_p+1)  current occupancy.

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr, each $clog2(els_p) bits, wrapping modulo els_p. Occupancy register count ranges 0..els_p. Storage array is not reset.
- Reset (asynchronous, reset_n_i=0):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Hence deq_v0_o=0, deq_v1_o=0, enq_ready_o=1, count_o=0.
  - Reset deasserting mid-operation leaves the queue empty.
- enq_ready_o = (count < els_p). It depends only on registered state; a same-cycle dequeue never raises it (no bypass).
- Enqueue fires when enq_v_i & enq_ready_o & !flush_i:
  - writes {instr, pc} at wr_ptr;
  - wr_ptr advances by 1.
- Read path:
  - slot 0 = entry[rd_ptr]; slot 1 = entry[rd_ptr+1 mod els_p].
  - Outputs are combinational from storage. An entry enqueued in cycle N is visible at the outputs in cycle N+1; there is no enqueue-to-dequeue bypass.
  - deq_v0_o = (count >= 1); deq_v1_o = (count >= 2).
- Empty slots: an invalid slot drives instr = 32'h00000013 (NOP) and pc = 0, so the decoder sees a harmless instruction.
- Pop count, when yumi_i & !flush_i:
  - 2 if deq_v1_o & !do_single_issue_i;
  - else 1.
  - rd_ptr advances by the pop count, mod els_p.
- yumi_i with deq_v0_o=0 is illegal:
  - simulation assertion fires;
  - RTL ignores the request (pop count 0).
- Next occupancy: count_next = count + enq_fire - pop_cnt. Simultaneous enqueue and pop in one cycle are both honoured.
- flush_i=1:
  - next cycle rd_ptr=wr_ptr=0 and count=0;
  - any enqueue or pop requested in the flush cycle is discarded;
  - flush has priority over everything except reset.
- Full (count=els_p): enq_ready_o=0. An enq_v_i in that cycle is not accepted, and fetch must hold it.
- Pointer wraparound is transparent: slot 1 may sit at index 0 while slot 0 sits at index els_p-1.
- The queue imposes no PC-contiguity rule; pairing legality is decided by decode via do_single_issue_i.

Test Plan:
- Reset and empty output: assert reset_n_i=0 mid-traffic with count=3 -> count_o=0, deq_v0_o=deq_v1_o=0, deq_instr0_o=deq_instr1_o=32'h00000013, enq_ready_o=1.
- Fill to full: enqueue PCs 0x10..0x13 on 4 consecutive cycles (els_p=4) with yumi_i=0 -> count_o=4, enq_ready_o=0. A 5th enq_v_i with PC 0x14 is not accepted, and slot 0 PC=0x10, slot 1 PC=0x11.
- Dual pop: from full, yumi_i=1 with do_single_issue_i=0 -> next cycle count_o=2, slot 0 PC=0x12, slot 1 PC=0x13.
- Single pop with simultaneous enqueue: count=2, yumi_i=1 with do_single_issue_i=1, and enqueue PC 0x14 -> count_o=2, slot 0 PC=0x13, slot 1 PC=0x14 (read across wraparound).
- Pop with one entry: count=1, yumi_i=1 with do_single_issue_i=0 -> deq_v1_o was 0, so exactly 1 pops; count_o=0.
- Flush mid-stream: count=3, with flush_i=1, enq_v_i=1 and yumi_i=1 in the same cycle -> next cycle count_o=0 and both valids low. A following enqueue of PC 0x40 appears in slot 0 one cycle later.
